// File: rtl/led_animator.sv
// Purpose: LED feedback engine for whack-a-mole (flash on hit, solid on miss, chase on game over, mole idle).
// Latency: registered outputs; o_leds/o_busy reflect the state entered on the same clock edge.
// Backpressure: none; event pulses are always accepted, retriggers restart the running animation.
module led_animator #(
  parameter int NUM_LEDS    = 8,
  parameter int POS_W       = 3,
  parameter int ANIM_CYCLES = 100000000,
  parameter int NUM_FLASHES = 3,
  parameter int STEP_CYCLES = 12500000,
  parameter bit SHOW_MOLE   = 1'b1,
  parameter int CNT_W       = 28
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_restart_game,
  input  logic                i_user_right,
  input  logic                i_user_wrong,
  input  logic                i_game_over,
  input  logic [POS_W-1:0]    i_mole_position,
  output logic [NUM_LEDS-1:0] o_leds,
  output logic                o_busy
);

  // FLASH alternates on/off phases, starting and ending with an on phase.
  localparam int NUM_PHASES = 2 * NUM_FLASHES - 1;
  localparam int PHASE_LEN  = ANIM_CYCLES / NUM_PHASES;
  localparam int PH_W       = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1;

  localparam logic [CNT_W-1:0]    PHASE_END   = CNT_W'(PHASE_LEN - 1);
  localparam logic [CNT_W-1:0]    SOLID_END   = CNT_W'(ANIM_CYCLES - 1);
  localparam logic [CNT_W-1:0]    STEP_END    = CNT_W'(STEP_CYCLES - 1);
  localparam logic [PH_W-1:0]     LAST_PHASE  = PH_W'(NUM_PHASES - 1);
  localparam logic [NUM_LEDS-1:0] ALL_ON      = '1;
  localparam logic [NUM_LEDS-1:0] CHASE_START = NUM_LEDS'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FLASH,
    S_SOLID,
    S_GAME_OVER
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [PH_W-1:0]     phase_q, phase_d;
  logic [NUM_LEDS-1:0] leds_q, leds_d;
  logic                busy_q, busy_d;
  logic [NUM_LEDS-1:0] idle_leds;

  // Idle display: one-hot mole position, dark when disabled or out of range.
  always_comb begin
    idle_leds = '0;
    if (SHOW_MOLE && (32'(i_mole_position) < NUM_LEDS)) begin
      idle_leds = CHASE_START << i_mole_position;
    end
  end

  // Next state, counters and LED pattern; restart beats game over beats right beats wrong.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    phase_d = phase_q;
    leds_d  = leds_q;

    if (i_restart_game) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      phase_d = '0;
      leds_d  = '0;
    end else if (i_game_over && (state_q != S_GAME_OVER)) begin
      state_d = S_GAME_OVER;
      cnt_d   = '0;
      phase_d = '0;
      leds_d  = CHASE_START;
    end else if (state_q == S_GAME_OVER) begin
      // Sticky chase: hit/miss events are ignored until restart or reset.
      if (cnt_q == STEP_END) begin
        cnt_d  = '0;
        leds_d = {leds_q[NUM_LEDS-2:0], leds_q[NUM_LEDS-1]};
      end
    end else if (i_user_right) begin
      state_d = S_FLASH;
      cnt_d   = '0;
      phase_d = '0;
      leds_d  = ALL_ON;
    end else if (i_user_wrong) begin
      state_d = S_SOLID;
      cnt_d   = '0;
      phase_d = '0;
      leds_d  = ALL_ON;
    end else begin
      case (state_q)
        S_FLASH: begin
          if (cnt_q == PHASE_END) begin
            cnt_d = '0;
            if (phase_q == LAST_PHASE) begin
              state_d = S_IDLE;
              phase_d = '0;
              leds_d  = idle_leds;
            end else begin
              phase_d = phase_q + PH_W'(1);
              // Leaving an odd (off) phase means the next one is on.
              leds_d  = phase_q[0] ? ALL_ON : '0;
            end
          end
        end
        S_SOLID: begin
          if (cnt_q == SOLID_END) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            leds_d  = idle_leds;
          end
        end
        default: begin
          cnt_d  = '0;
          leds_d = idle_leds;
        end
      endcase
    end

    busy_d = (state_d == S_FLASH) || (state_d == S_SOLID);
  end

  // State, counter and output registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      phase_q <= '0;
      leds_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      leds_q  <= leds_d;
      busy_q  <= busy_d;
    end
  end

  assign o_leds = leds_q;
  assign o_busy = busy_q;

endmodule

// File: tb/tb_led_animator.sv
// Bench for led_animator: directed scenarios with literal expectations plus a randomized run,
// all outputs compared every cycle against a timeline model (mode + time since entry).
// Inputs change 1 time unit after the rising edge; outputs are compared on the falling edge.
module tb_led_animator;

  localparam int NUM_LEDS    = 8;
  localparam int POS_W       = 4;
  localparam int ANIM_CYCLES = 50;
  localparam int NUM_FLASHES = 3;
  localparam int STEP_CYCLES = 4;
  localparam int CNT_W       = 8;
  localparam int FLASH_PH    = ANIM_CYCLES / (2 * NUM_FLASHES - 1);
  localparam int FLASH_TOTAL = FLASH_PH * (2 * NUM_FLASHES - 1);

  localparam int M_IDLE  = 0;
  localparam int M_FLASH = 1;
  localparam int M_SOLID = 2;
  localparam int M_GO    = 3;

  logic             i_clk;
  logic             i_rst_n;
  logic             i_restart_game;
  logic             i_user_right;
  logic             i_user_wrong;
  logic             i_game_over;
  logic [POS_W-1:0] i_mole_position;
  logic [7:0]       o_leds;
  logic             o_busy;

  int tests = 0;
  int fails = 0;

  led_animator #(
    .NUM_LEDS   (NUM_LEDS),
    .POS_W      (POS_W),
    .ANIM_CYCLES(ANIM_CYCLES),
    .NUM_FLASHES(NUM_FLASHES),
    .STEP_CYCLES(STEP_CYCLES),
    .SHOW_MOLE  (1'b1),
    .CNT_W      (CNT_W)
  ) dut (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_restart_game (i_restart_game),
    .i_user_right   (i_user_right),
    .i_user_wrong   (i_user_wrong),
    .i_game_over    (i_game_over),
    .i_mole_position(i_mole_position),
    .o_leds         (o_leds),
    .o_busy         (o_busy)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  // ---------------- behavioural model ----------------
  int               m_mode = M_IDLE;
  int               m_t    = 0;
  bit               m_zero = 1'b1;
  logic [POS_W-1:0] m_pos  = '0;

  function automatic logic [7:0] one_hot(input int idx);
    logic [7:0] v;
    v = 8'd1;
    return v << idx;
  endfunction

  function automatic logic [7:0] model_leds();
    int ph;
    case (m_mode)
      M_FLASH: begin
        ph = m_t / FLASH_PH;
        return (ph % 2 == 0) ? 8'hFF : 8'h00;
      end
      M_SOLID: return 8'hFF;
      M_GO:    return one_hot((m_t / STEP_CYCLES) % NUM_LEDS);
      default: begin
        if (m_zero) return 8'h00;
        if (int'(m_pos) < NUM_LEDS) return one_hot(int'(m_pos));
        return 8'h00;
      end
    endcase
  endfunction

  always @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      m_mode = M_IDLE;
      m_t    = 0;
      m_zero = 1'b1;
    end else begin
      m_zero = 1'b0;
      m_pos  = i_mole_position;
      if (i_restart_game) begin
        m_mode = M_IDLE;
        m_t    = 0;
        m_zero = 1'b1;
      end else if (i_game_over && m_mode != M_GO) begin
        m_mode = M_GO;
        m_t    = 0;
      end else if (m_mode == M_GO) begin
        m_t = m_t + 1;
      end else if (i_user_right) begin
        m_mode = M_FLASH;
        m_t    = 0;
      end else if (i_user_wrong) begin
        m_mode = M_SOLID;
        m_t    = 0;
      end else if (m_mode == M_FLASH || m_mode == M_SOLID) begin
        m_t = m_t + 1;
        if ((m_mode == M_FLASH && m_t >= FLASH_TOTAL) ||
            (m_mode == M_SOLID && m_t >= ANIM_CYCLES)) begin
          m_mode = M_IDLE;
          m_t    = 0;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  logic [7:0] exp_leds;
  logic       exp_busy;

  always @(negedge i_clk) begin
    exp_leds = model_leds();
    exp_busy = (m_mode == M_FLASH) || (m_mode == M_SOLID);
    tests = tests + 1;
    if (o_leds !== exp_leds || o_busy !== exp_busy) begin
      fails = fails + 1;
      $display("FAIL model_cycle @%0t: leds=%h busy=%b, expected leds=%h busy=%b",
               $time, o_leds, o_busy, exp_leds, exp_busy);
    end
  end

  // ---------------- helpers ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  task automatic check_lit(input string name, input logic [7:0] el, input logic eb);
    tests = tests + 1;
    if (o_leds !== el || o_busy !== eb) begin
      fails = fails + 1;
      $display("FAIL %s: leds=%h busy=%b, expected leds=%h busy=%b", name, o_leds, o_busy, el, eb);
    end
  endtask

  task automatic chk(input string name, input logic [7:0] el, input logic eb);
    @(negedge i_clk);
    check_lit(name, el, eb);
  endtask

  // One-cycle event strobe: r=right, w=wrong, g=game_over, s=restart.
  task automatic drive(input logic r, input logic w, input logic g, input logic s);
    i_user_right   = r;
    i_user_wrong   = w;
    i_game_over    = g;
    i_restart_game = s;
    tick(1);
    i_user_right   = 1'b0;
    i_user_wrong   = 1'b0;
    i_game_over    = 1'b0;
    i_restart_game = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    i_rst_n         = 1'b0;
    i_restart_game  = 1'b0;
    i_user_right    = 1'b0;
    i_user_wrong    = 1'b0;
    i_game_over     = 1'b0;
    i_mole_position = 4'd5;

    chk("reset_state", 8'h00, 1'b0);
    @(posedge i_clk);
    #1 i_rst_n = 1'b1;
    tick(1);
    chk("idle_pos5", 8'h20, 1'b0);

    // Hit: five 10-clock phases on/off/on/off/on.
    drive(1, 0, 0, 0);
    chk("flash_first", 8'hFF, 1'b1);
    tick(9);  chk("flash_on_end", 8'hFF, 1'b1);
    tick(1);  chk("flash_off", 8'h00, 1'b1);
    tick(39); chk("flash_last", 8'hFF, 1'b1);
    tick(1);  chk("flash_done", 8'h20, 1'b0);

    // Miss: solid for exactly 50 clocks.
    drive(0, 1, 0, 0);
    chk("solid_first", 8'hFF, 1'b1);
    tick(49); chk("solid_last", 8'hFF, 1'b1);
    tick(1);  chk("solid_done", 8'h20, 1'b0);

    // Miss retriggered at clock 30 extends solid to clock 80.
    drive(0, 1, 0, 0);
    tick(29);
    drive(0, 1, 0, 0);
    tick(49); chk("solid_retrig_last", 8'hFF, 1'b1);
    tick(1);  chk("solid_retrig_done", 8'h20, 1'b0);

    // Hit at clock 15 of solid restarts the flash from phase 0.
    drive(0, 1, 0, 0);
    tick(14);
    drive(1, 0, 0, 0);
    chk("solid_to_flash", 8'hFF, 1'b1);
    tick(9);  chk("s2f_on_end", 8'hFF, 1'b1);
    tick(1);  chk("s2f_off", 8'h00, 1'b1);
    tick(40); chk("s2f_done", 8'h20, 1'b0);

    // Asynchronous reset mid-flash clears outputs without a clock edge.
    drive(1, 0, 0, 0);
    tick(5);
    #2 i_rst_n = 1'b0;
    #1 check_lit("reset_async", 8'h00, 1'b0);
    @(posedge i_clk);
    #1 i_rst_n = 1'b1;
    tick(1);  chk("after_reset_idle", 8'h20, 1'b0);

    // Game over chase; hit/miss ignored; restart returns to idle.
    drive(0, 0, 1, 0);
    chk("go_entry", 8'h01, 1'b0);
    tick(3);  chk("go_step0_end", 8'h01, 1'b0);
    tick(1);  chk("go_step1", 8'h02, 1'b0);
    drive(1, 0, 0, 0);
    drive(0, 1, 0, 0);
    tick(2);  chk("go_ignore_events", 8'h04, 1'b0);
    tick(24); chk("go_wrap", 8'h01, 1'b0);
    drive(0, 0, 0, 1);
    chk("restart_zero", 8'h00, 1'b0);
    tick(1);  chk("restart_idle", 8'h20, 1'b0);

    // Same-cycle priorities and out-of-range position.
    drive(1, 0, 1, 1);
    chk("prio_restart", 8'h00, 1'b0);
    tick(1);  chk("prio_restart_idle", 8'h20, 1'b0);
    drive(1, 0, 1, 0);
    chk("prio_go_over_right", 8'h01, 1'b0);
    drive(0, 0, 0, 1);
    i_mole_position = 4'd9;
    tick(1);  chk("pos_out_of_range", 8'h00, 1'b0);
    i_mole_position = 4'd7;
    tick(1);  chk("pos_msb", 8'h80, 1'b0);

    // Randomized traffic, checked every cycle by the model compare.
    for (int i = 0; i < 3000; i++) begin
      i_rst_n        = ($urandom_range(0, 599) != 0);
      i_restart_game = ($urandom_range(0, 79) == 0);
      i_game_over    = ($urandom_range(0, 149) == 0);
      i_user_right   = ($urandom_range(0, 29) == 0);
      i_user_wrong   = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 7) == 0) i_mole_position = POS_W'($urandom_range(0, 15));
      tick(1);
    end
    i_rst_n        = 1'b1;
    i_restart_game = 1'b0;
    i_game_over    = 1'b0;
    i_user_right   = 1'b0;
    i_user_wrong   = 1'b0;
    tick(2);

    @(negedge i_clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
